// File: rtl/sram_array_ctl.sv
`default_nettype none
// ============================================================================
// Module   : sram_array_ctl
// Purpose  : Synchronous SRAM macro model with active-low byte write enables,
//            a 1- or 2-stage registered read pipeline with a valid strobe,
//            a selectable write-port read-back mode, and an optional
//            clear-on-reset sequencer that zeroes the array after reset.
// Revision : 1.0  initial release
// ============================================================================
module sram_array_ctl #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 6,
  parameter int READ_LAT       = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                bCS,
  input  logic                bWE,
  input  logic [DATA_W/8-1:0] bBE,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [DATA_W-1:0]   InData,
  output logic [DATA_W-1:0]   OutData,
  output logic                OutValid,
  output logic                Ready
);

  localparam int NBYTE = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  // Any value other than 2 collapses to a single pipeline stage.
  localparam int LAT   = (READ_LAT == 2) ? 2 : 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t ST_RESET = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [LAT-1:0]      pipe_vld_q, pipe_vld_d;
  logic [DATA_W-1:0]   pipe_dat_q [LAT];
  logic [DATA_W-1:0]   pipe_dat_d [LAT];
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_vld_q, out_vld_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   merged_word;
  logic                acc_rd;
  logic                acc_wr;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign rd_word = mem[Addr];
  assign acc_wr  = (state_q == ST_RUN) && !bCS && !bWE;
  assign acc_rd  = (state_q == ST_RUN) && !bCS &&  bWE;
  assign Ready   = (state_q == ST_RUN);

  // Byte-merge: masked-off bytes keep the stored value, so an all-high mask
  // rewrites the word unchanged.
  generate
    for (genvar gi = 0; gi < NBYTE; gi++) begin : g_byte
      assign merged_word[8*gi +: 8] = bBE[gi] ? rd_word[8*gi +: 8]
                                              : InData[8*gi +: 8];
    end
  endgenerate

  // Next-state for sequencer, read pipeline, output registers and array port.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pipe_vld_d = pipe_vld_q;
    for (int i = 0; i < LAT; i++) pipe_dat_d[i] = pipe_dat_q[i];
    mem_we     = 1'b0;
    mem_waddr  = Addr;
    mem_wdata  = merged_word;

    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
    end else begin
      mem_we = acc_wr;
    end

    // Stage 0 captures the read word, or the merged word in write-through.
    pipe_vld_d[0] = acc_rd || (acc_wr && (WRITE_MODE != 0));
    pipe_dat_d[0] = acc_wr ? merged_word : rd_word;
    for (int i = 1; i < LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end

    // Output holds its last value whenever nothing retires this cycle.
    out_vld_d  = pipe_vld_q[LAT-1];
    out_data_d = pipe_vld_q[LAT-1] ? pipe_dat_q[LAT-1] : out_data_q;
  end

  // Control and pipeline registers; reset flushes all in-flight reads.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < LAT; i++) pipe_dat_q[i] <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < LAT; i++) pipe_dat_q[i] <= pipe_dat_d[i];
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
    end
  end

  // Storage array has no reset; a write coinciding with a reset edge is dropped.
  always_ff @(posedge Clk) begin
    if (mem_we && !Reset) mem[mem_waddr] <= mem_wdata;
  end

  assign OutData  = out_data_q;
  assign OutValid = out_vld_q;

endmodule
`default_nettype wire

// File: doc/sram_array_ctl.md
Name: sram_array_ctl

Overview:
- Parametrised synchronous SRAM macro model; next generation of the single-bit asynchronous SRAM cell.
- Adds:
  - configurable data width and depth
  - active-low byte write enables
  - registered read pipeline with valid strobe
  - selectable write-port read-back mode
  - optional hardware clear-on-reset sequencer
- Sits between the bus interface and the storage array; keeps the active-low bCS/bWE access convention of the existing cell.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
ADDR_W, 6, address width; DEPTH = 2**ADDR_W words
READ_LAT, 1, read latency in clocks; legal values 1 or 2
WRITE_MODE, 0, 0 = no-change (OutData holds on write); 1 = write-through (merged write data returned)
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting accesses; 0 = contents untouched

Ports:
Clk  input  1  clock; all state changes on rising edge
Reset  input  1  asynchronous, active-high reset
bCS  input  1  chip select, active low
bWE  input  1  write enable, active low; sampled only when bCS = 0
bBE  input  DATA_W/8  byte enables, active low; bit i gates InData[8i+7:8i]
Addr  input  ADDR_W  word address
InData  input  DATA_W  write data
OutData  output  DATA_W  read data; registered
OutValid  output  1  one-cycle strobe; OutData updated this cycle
Ready  output  1  high when accesses are accepted

Behaviour:
- Reset (async assert):
  - OutData = 0, OutValid = 0
  - read pipeline flushed
  - init counter = 0
  - state = INIT if CLEAR_ON_RESET = 1, else RUN
  - Ready = (state == RUN), combinational: 0 during reset when CLEAR_ON_RESET = 1, else 1
- Memory array is not asynchronously reset.
- State INIT (CLEAR_ON_RESET = 1 only):
  - each clock writes all-zero to Mem[cnt], cnt++
  - after the write of address DEPTH-1 (exactly DEPTH clocks), go to RUN
  - Ready = 0 throughout
  - bCS/bWE/Addr ignored; OutValid stays 0
- State RUN: access decoded each rising edge from bCS, bWE.
  - Write (bCS = 0, bWE = 0):
    - for each byte i with bBE[i] = 0, Mem[Addr] byte i <= InData byte i
    - bytes with bBE[i] = 1 are unchanged
    - all bBE high: no memory change, still counts as a write access
  - Read (bCS = 0, bWE = 1):
    - Mem[Addr] captured at the access edge
    - bBE ignored; full word returned
  - Idle (bCS = 1): no access; bWE/bBE/Addr/InData don't-care.
- Read latency:
  - access sampled at edge N
  - READ_LAT = 1: OutData/OutValid update at edge N+1
  - READ_LAT = 2: update at edge N+2
  - fully pipelined: back-to-back reads every cycle return in order, one per cycle
- Write return:
  - WRITE_MODE = 0: a write produces no pipeline entry; OutData holds, OutValid = 0 for that slot
  - WRITE_MODE = 1: the post-write merged word enters the pipeline and appears after READ_LAT with OutValid = 1
- OutData holds its last value whenever OutValid = 0 (deselect never clears or X-es the output).
- Read-after-write to the same address on the next edge returns the newly written data (no bypass hazard).
- Address wrap: Addr is exactly ADDR_W bits; no out-of-range case.
- Reset mid-operation:
  - in-flight reads discarded, OutValid = 0
  - INIT restarts from address 0 if CLEAR_ON_RESET = 1
  - a write at the reset edge is not performed
- X on bCS or bWE in RUN: treated as an access with unknown effect; bench flags it as an error. No X-propagation guarantee.

Test Plan:
- CLEAR_ON_RESET = 1, DEPTH = 64: pulse Reset, hold bCS = 0 bWE = 1 throughout -> Ready = 0 for exactly 64 clocks, then 1; read of every address returns 0; no OutValid during INIT.
- READ_LAT = 1: write 0xDEADBEEF to addr 5, bBE = 0000; next cycle read addr 5 -> OutData = 0xDEADBEEF with OutValid high one edge after the read.
- Byte mask: addr 5 = 0xDEADBEEF; write 0x11223344 with bBE = 1010 -> read returns 0xDE22BE44.
- READ_LAT = 2: reads of addr 1, 2, 3 on consecutive cycles (contents 0xA, 0xB, 0xC) -> OutValid high 3 consecutive cycles starting 2 edges after the first read; data 0xA, 0xB, 0xC in order.
- WRITE_MODE = 1 vs 0: write 0x55 to addr 9 -> mode 1: OutData = 0x55 with OutValid after READ_LAT; mode 0: OutData holds the prior value, OutValid stays 0. Then bCS = 1 for 4 cycles -> OutData unchanged.
- Assert Reset during a 2-deep read burst -> OutValid never asserts for the flushed reads; OutData = 0; INIT restarts (Ready low 64 cycles).
